// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg
// Shared types and constants for the multiplier arbiter slice.
//   state_t     : controller FSM states, one per bus phase of a job
//   FUNC_*      : encodings of the multiplier's func input
// Optional feature macro used by the slice: MULT_ARB_TIMEOUT_EN (see mult_arbiter).
package mult_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    START,
    WAIT,
    READ_LO,
    READ_HI,
    DONE
  } state_t;

  localparam logic [1:0] FUNC_LOAD_A = 2'b00;
  localparam logic [1:0] FUNC_LOAD_B = 2'b01;
  localparam logic [1:0] FUNC_READ   = 2'b10;
  localparam logic [1:0] FUNC_RUN    = 2'b11;

endpackage

// File: rtl/mult_arbiter_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter with a one-bit preference pointer.
//   clock    in   system clock
//   n_reset  in   synchronous active-low reset, pointer returns to requester 0
//   req_i    in   [1:0] request lines
//   ack_i    in   [1:0] completion pulse of the job that was granted
//   grant_o  out  [1:0] one-hot grant (combinational from req_i and pointer)
module rr_arb2 (
  input  logic       clock,
  input  logic       n_reset,
  input  logic [1:0] req_i,
  input  logic [1:0] ack_i,
  output logic [1:0] grant_o
);

  logic ptr_q;
  logic ptr_d;

  // The pointer names the preferred requester. Once a requester's job is
  // acknowledged, preference moves to the other side so neither can starve.
  always_comb begin
    ptr_d = ptr_q;
    if (ack_i[0]) begin
      ptr_d = 1'b1;
    end else if (ack_i[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // A lone request always wins; the pointer only breaks ties.
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter
// Shares one bus-based multiplier between two requesters. Each job loads A
// and B over the tri-state bus, starts the multiply, waits for ready, reads
// the 2n-bit product in two halves and returns it with a one-cycle ack.
// Ports:
//   clock, n_reset      clock and synchronous active-low reset
//   req[1:0]            job requests; operands stable until the matching ack
//   a0,b0 / a1,b1       operands of requester 0 / 1
//   ack[1:0]            one-cycle completion pulse, result valid in that cycle
//   result[2n-1:0]      product of the last completed job
//   busy                controller not idle
//   err                 timeout abort pulse, coincident with ack
//   m_func,m_start,m_oe multiplier control
//   m_data              shared tri-state bus, driven here only while loading
//   m_ready             multiplier ready
// Optional feature: define MULT_ARB_TIMEOUT_EN to bound the WAIT phase to
// TIMEOUT cycles; without it WAIT is unbounded and err is tied low.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int n       = 8,
  parameter int TIMEOUT = 32
) (
  input  logic           clock,
  input  logic           n_reset,
  input  logic [1:0]     req,
  input  logic [n-1:0]   a0,
  input  logic [n-1:0]   b0,
  input  logic [n-1:0]   a1,
  input  logic [n-1:0]   b1,
  output logic [1:0]     ack,
  output logic [2*n-1:0] result,
  output logic           busy,
  output logic           err,
  output logic [1:0]     m_func,
  output logic           m_start,
  output logic           m_oe,
  inout  wire  [n-1:0]   m_data,
  input  logic           m_ready
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mult_arbiter: TIMEOUT must be at least 1");
  end

  state_t         state_q, state_d;
  logic           gnt_q, gnt_d;
  logic           firstWait_q, firstWait_d;
  logic [n-1:0]   lo_q, lo_d;
  logic [2*n-1:0] result_q, result_d;
  logic [1:0]     grant;
  logic           busDrive;
  logic [n-1:0]   busVal;
  logic           timeoutHit;

  rr_arb2 u_arb (
    .clock   (clock),
    .n_reset (n_reset),
    .req_i   (req),
    .ack_i   (ack),
    .grant_o (grant)
  );

  assign m_data = busDrive ? busVal : {n{1'bz}};
  assign ack    = (state_q == DONE) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy   = (state_q != IDLE);
  assign result = result_q;

  // Next-state and multiplier control. The grant is latched on leaving IDLE
  // and held for the whole job. The low product half is staged in lo_q so
  // that result only changes as the job completes, never mid-read.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    firstWait_d = 1'b0;
    lo_d        = lo_q;
    result_d    = result_q;
    m_func      = FUNC_RUN;
    m_start     = 1'b0;
    m_oe        = 1'b0;
    busDrive    = 1'b0;
    busVal      = '0;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          gnt_d   = grant[1];
          state_d = LOAD_A;
        end
      end
      LOAD_A: begin
        m_func   = FUNC_LOAD_A;
        busDrive = 1'b1;
        busVal   = gnt_q ? a1 : a0;
        state_d  = LOAD_B;
      end
      LOAD_B: begin
        m_func   = FUNC_LOAD_B;
        busDrive = 1'b1;
        busVal   = gnt_q ? b1 : b0;
        state_d  = START;
      end
      START: begin
        m_start     = 1'b1;
        firstWait_d = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        // ready may still reflect the previous job in the first WAIT cycle
        if (!firstWait_q && m_ready) begin
          state_d = READ_LO;
        end else if (timeoutHit) begin
          result_d = '0;
          state_d  = DONE;
        end
      end
      READ_LO: begin
        m_func  = FUNC_READ;
        m_oe    = 1'b1;
        lo_d    = m_data;
        state_d = READ_HI;
      end
      READ_HI: begin
        m_oe     = 1'b1;
        result_d = {m_data, lo_q};
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any job in flight.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      firstWait_q <= 1'b0;
      lo_q        <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      firstWait_q <= firstWait_d;
      lo_q        <= lo_d;
      result_q    <= result_d;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] waitCnt_q, waitCnt_d;
  logic            timedOut_q, timedOut_d;

  assign timeoutHit = (waitCnt_q == CntW'(TIMEOUT - 1));
  assign err        = (state_q == DONE) && timedOut_q;

  // WAIT-cycle counter, zero on entry to WAIT. timedOut_q remembers that
  // the job ended by abort so DONE can flag it; a late ready wins a tie.
  always_comb begin
    waitCnt_d  = '0;
    timedOut_d = timedOut_q;
    if (state_q == WAIT) begin
      waitCnt_d = waitCnt_q + 1'b1;
      if (timeoutHit && !(m_ready && !firstWait_q)) begin
        timedOut_d = 1'b1;
      end
    end else if (state_q == IDLE) begin
      timedOut_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      waitCnt_q  <= '0;
      timedOut_q <= 1'b0;
    end else begin
      waitCnt_q  <= waitCnt_d;
      timedOut_q <= timedOut_d;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter
// Directed bench for mult_arbiter driving a behavioural bus multiplier.
// Expected responses are queued at issue time and checked by a monitor
// whenever ack is seen; bus rules are checked every cycle.
// Define MULT_ARB_TIMEOUT_EN to also exercise the timeout abort.
module tb_mult_arbiter;

  typedef struct {
    logic [1:0]  ack;
    logic [15:0] res;
    logic        err;
    int          lat;
  } exp_t;

  logic        clock = 1'b0;
  logic        n_reset;
  logic [1:0]  req;
  logic [7:0]  a0, b0, a1, b1;
  logic [1:0]  ack;
  logic [15:0] result;
  logic        busy, err;
  logic [1:0]  m_func;
  logic        m_start, m_oe;
  wire  [7:0]  m_data;
  logic        m_ready;

  logic [7:0]  mA, mB;
  logic [15:0] mProd = 16'h0000;
  logic        mReady = 1'b1;
  logic [2:0]  mCnt = 3'd0;
  logic        noReady = 1'b0;

  exp_t        sb[$];
  int          cycle = 0;
  int          issueCycle = 0;
  int          checks = 0;
  int          errors = 0;
  logic [1:0]  seen;

  always #5 clock = ~clock;

  mult_arbiter dut (
    .clock   (clock),
    .n_reset (n_reset),
    .req     (req),
    .a0      (a0),
    .b0      (b0),
    .a1      (a1),
    .b1      (b1),
    .ack     (ack),
    .result  (result),
    .busy    (busy),
    .err     (err),
    .m_func  (m_func),
    .m_start (m_start),
    .m_oe    (m_oe),
    .m_data  (m_data),
    .m_ready (m_ready)
  );

  // Behavioural multiplier: three-cycle compute, ready low while running.
  always @(posedge clock) begin
    cycle <= cycle + 1;
    if (m_func == 2'b00) mA <= m_data;
    if (m_func == 2'b01) mB <= m_data;
    if (m_func == 2'b11 && m_start) begin
      mCnt   <= 3'd3;
      mReady <= 1'b0;
    end else if (mCnt != 3'd0) begin
      if (mCnt == 3'd1) begin
        mProd  <= mA * mB;
        mReady <= 1'b1;
      end
      mCnt <= mCnt - 3'd1;
    end
  end

  assign m_ready = mReady && !noReady;
  assign m_data  = (m_oe && m_func == 2'b10) ? mProd[7:0] :
                   (m_oe && m_func == 2'b11 && !m_start) ? mProd[15:8] : 8'bz;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r);
    issueCycle = cycle;
    req = r;
  endtask

  task automatic waitAck(input int budget, output logic [1:0] got);
    int k;
    got = 2'b00;
    k = 0;
    while (k < budget) begin
      @(negedge clock);
      if (ack !== 2'b00) begin
        got = ack;
        break;
      end
      k++;
    end
    if (got == 2'b00) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout actual=none expected=ack within %0d cycles", budget);
    end
  endtask

  // Scoreboard monitor and per-cycle bus rules.
  always @(negedge clock) begin
    exp_t e;
    if (n_reset === 1'b1) begin
      if (ack !== 2'b00) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_ack actual=%b expected=no ack", ack);
        end else begin
          e = sb.pop_front();
          if (ack !== e.ack || result !== e.res || err !== e.err) begin
            errors++;
            $display("[TB] FAIL job actual ack=%b res=0x%h err=%b expected ack=%b res=0x%h err=%b",
                     ack, result, err, e.ack, e.res, e.err);
          end
          if (e.lat >= 0) begin
            checks++;
            if (cycle - issueCycle != e.lat) begin
              errors++;
              $display("[TB] FAIL latency actual=%0d expected=%0d", cycle - issueCycle, e.lat);
            end
          end
        end
      end
      checks++;
      if ((m_start === 1'b1 && m_func !== 2'b11) ||
          (m_oe === 1'b1 && m_func[1] !== 1'b1) ||
          (m_func === 2'b10 && m_oe === 1'b1 && m_data !== mProd[7:0]) ||
          (m_func === 2'b11 && m_oe === 1'b1 && m_data !== mProd[15:8]) ||
          (m_func[1] === 1'b0 && ^m_data === 1'bx) ||
          (busy === 1'b0 && m_oe === 1'b0 &&
           (m_data === a0 || m_data === b0 || m_data === a1 || m_data === b1))) begin
        errors++;
        $display("[TB] FAIL bus_rule actual func=%b start=%b oe=%b data=%h busy=%b expected legal bus",
                 m_func, m_start, m_oe, m_data, busy);
      end
    end
  end

  initial begin
    n_reset = 1'b0;
    req = 2'b00;
    a0 = 8'h11; b0 = 8'h22; a1 = 8'h33; b1 = 8'h44;
    repeat (3) @(negedge clock);
    checkOutput("reset_ack", ack, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_result", result, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_func", m_func, 3);
    checkOutput("reset_start", m_start, 0);
    checkOutput("reset_oe", m_oe, 0);
    n_reset = 1'b1;
    @(negedge clock);

    $display("[TB] test1 req0 123*234");
    a0 = 8'd123; b0 = 8'd234;
    sb.push_back('{2'b01, 16'h706E, 1'b0, 10});
    applyStimulus(2'b01);
    waitAck(40, seen);
    req = 2'b00;
    @(negedge clock);
    checkOutput("t1_busy_after", busy, 0);
    checkOutput("t1_result_hold", result, 16'h706E);

    $display("[TB] test2 req1 0x55*0xAA");
    a1 = 8'h55; b1 = 8'hAA;
    sb.push_back('{2'b10, 16'h3872, 1'b0, 10});
    applyStimulus(2'b10);
    waitAck(40, seen);
    req = 2'b00;
    @(negedge clock);

    $display("[TB] boundary 255*255");
    a0 = 8'hFF; b0 = 8'hFF;
    sb.push_back('{2'b01, 16'hFE01, 1'b0, 10});
    applyStimulus(2'b01);
    waitAck(40, seen);
    req = 2'b00;
    @(negedge clock);

    $display("[TB] test3 round robin after reset");
    n_reset = 1'b0;
    a0 = 8'd12; b0 = 8'd13; a1 = 8'd200; b1 = 8'd3;
    repeat (2) @(negedge clock);
    n_reset = 1'b1;
    @(negedge clock);
    sb.push_back('{2'b01, 16'h009C, 1'b0, 10});
    sb.push_back('{2'b10, 16'h0258, 1'b0, -1});
    sb.push_back('{2'b01, 16'h009C, 1'b0, -1});
    sb.push_back('{2'b10, 16'h0258, 1'b0, -1});
    applyStimulus(2'b11);
    waitAck(40, seen);
    checkOutput("rr_order_1", seen, 2'b01);
    waitAck(40, seen);
    checkOutput("rr_order_2", seen, 2'b10);
    waitAck(40, seen);
    checkOutput("rr_order_3", seen, 2'b01);
    req = 2'b10;
    waitAck(40, seen);
    checkOutput("rr_order_4", seen, 2'b10);
    req = 2'b00;
    @(negedge clock);

    $display("[TB] test4 reset during WAIT");
    a0 = 8'h21; b0 = 8'h03;
    applyStimulus(2'b01);
    repeat (5) @(negedge clock);
    checkOutput("t4_in_wait_busy", busy, 1);
    n_reset = 1'b0;
    req = 2'b00;
    @(negedge clock);
    checkOutput("t4_busy", busy, 0);
    checkOutput("t4_oe", m_oe, 0);
    checkOutput("t4_ack", ack, 0);
    checkOutput("t4_result", result, 0);
    checkOutput("t4_bus_released", (m_data !== a0) && (m_data !== b0), 1);
    n_reset = 1'b1;
    repeat (4) @(negedge clock);
    checkOutput("t4_no_late_ack", sb.size(), 0);
    a0 = 8'd7; b0 = 8'd9;
    sb.push_back('{2'b01, 16'h003F, 1'b0, 10});
    applyStimulus(2'b01);
    waitAck(40, seen);
    req = 2'b00;
    @(negedge clock);

`ifdef MULT_ARB_TIMEOUT_EN
    $display("[TB] test6 timeout abort");
    noReady = 1'b1;
    a1 = 8'd9; b1 = 8'd9;
    sb.push_back('{2'b10, 16'h0000, 1'b1, 36});
    applyStimulus(2'b10);
    waitAck(100, seen);
    req = 2'b00;
    @(negedge clock);
    checkOutput("t6_err_pulse", err, 0);
    noReady = 1'b0;
    repeat (4) @(negedge clock);
`endif

    repeat (3) @(negedge clock);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
